phy_rx_frame: RTL and testbench

Receive framer directly downstream of the RGMII input DDR stage. It takes the per-clock rising/falling nibble pairs for RXD[3:0] and RX_CTL and reassembles bytes. It strips preamble/SFD, checks FCS and length, and emits each frame as a byte stream with last/error marking into the MAC receive path. There is no back-pressure, because the PHY cannot be stalled.

---
 rtl/phy_rx_pkg.sv | 27 ++
 rtl/phy_crc32_d8.sv | 21 ++
 rtl/phy_rx_frame.sv | 195 +++++++++++++++++++
 tb/tb_phy_rx_frame.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// Shared constants and types for the RGMII receive framer and the CRC-32 helper.
// The TX path imports the same package for its FCS generator.
package phy_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  PRE_BYTE      = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  localparam logic [15:0] MIN_FRAME_LEN = 16'd64;
  localparam logic [3:0]  PRE_CNT_MAX   = 4'hF;

  // Frame length counter saturates so a runaway carrier cannot wrap into a legal length.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/phy_crc32_d8.sv
// Combinational byte-wide update of the reflected Ethernet CRC-32 (no final inversion).
// Shared between the RX residue check and the TX FCS generator.
module phy_crc32_d8
  import phy_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/phy_rx_frame.sv
// RGMII receive framer: rebuilds bytes from the DDR nibble pairs, strips preamble/SFD,
// checks FCS and length, and streams each frame with last/bad marking. No back-pressure.
module phy_rx_frame
  import phy_rx_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned MAX_LEN      = 1518
) (
  input  logic       phy_clk,
  input  logic       phy_rst,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       rxctl_q1,
  input  logic       rxctl_q2,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_frame_ok,
  output logic       stat_frame_bad,
  output logic       stat_pre_err
);

  localparam logic [1:0] S_IDLE     = ST_IDLE;
  localparam logic [1:0] S_PREAMBLE = ST_PREAMBLE;
  localparam logic [1:0] S_PAYLOAD  = ST_PAYLOAD;
  localparam logic [1:0] S_DROP     = ST_DROP;

  // Input stage
  logic [7:0]  r_byte;
  logic        r_dv;
  logic        r_er;

  // Framer state
  logic [1:0]  state_reg,   state_next;
  logic [3:0]  pre_cnt_reg, pre_cnt_next;
  logic [31:0] crc_reg,     crc_next;
  logic [15:0] len_reg,     len_next;
  logic        err_reg,     err_next;
  logic        rst_hold_reg;

  // Registered outputs
  logic [7:0]  tdata_reg,   tdata_next;
  logic        tvalid_reg,  tvalid_next;
  logic        tlast_reg,   tlast_next;
  logic        tuser_reg,   tuser_next;
  logic        ok_reg,      ok_next;
  logic        bad_reg,     bad_next;
  logic        pre_err_reg, pre_err_next;

  // Per-byte datapath
  logic [31:0] crc_calc;
  logic [15:0] len_inc;
  logic        err_inc;
  logic        frame_bad;
  logic        pre_ok;

  phy_crc32_d8 u_crc (
    .crc_in  (crc_reg),
    .data    (r_byte),
    .crc_out (crc_calc)
  );

  assign len_inc   = sat_inc16(len_reg);
  assign err_inc   = err_reg | r_er;
  assign pre_ok    = (32'(pre_cnt_reg) >= MIN_PREAMBLE);
  assign frame_bad = err_inc
                   | (crc_calc != CRC_RESIDUE)
                   | (len_inc < MIN_FRAME_LEN)
                   | (32'(len_inc) > MAX_LEN);

  always_ff @(posedge phy_clk) begin
    if (phy_rst) begin
      r_byte       <= 8'h00;
      r_dv         <= 1'b0;
      r_er         <= 1'b0;
      state_reg    <= S_DROP;
      pre_cnt_reg  <= 4'd0;
      crc_reg      <= CRC_INIT;
      len_reg      <= 16'd0;
      err_reg      <= 1'b0;
      rst_hold_reg <= 1'b1;
      tdata_reg    <= 8'h00;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      tuser_reg    <= 1'b0;
      ok_reg       <= 1'b0;
      bad_reg      <= 1'b0;
      pre_err_reg  <= 1'b0;
    end else begin
      r_byte       <= {rxd_q2, rxd_q1};
      r_dv         <= rxctl_q1;
      r_er         <= rxctl_q1 ^ rxctl_q2;
      state_reg    <= state_next;
      pre_cnt_reg  <= pre_cnt_next;
      crc_reg      <= crc_next;
      len_reg      <= len_next;
      err_reg      <= err_next;
      rst_hold_reg <= 1'b0;
      tdata_reg    <= tdata_next;
      tvalid_reg   <= tvalid_next;
      tlast_reg    <= tlast_next;
      tuser_reg    <= tuser_next;
      ok_reg       <= ok_next;
      bad_reg      <= bad_next;
      pre_err_reg  <= pre_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pre_cnt_next = pre_cnt_reg;
    crc_next     = crc_reg;
    len_next     = len_reg;
    err_next     = err_reg;
    tdata_next   = 8'h00;
    tvalid_next  = 1'b0;
    tlast_next   = 1'b0;
    tuser_next   = 1'b0;
    ok_next      = 1'b0;
    bad_next     = 1'b0;
    pre_err_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (r_dv) begin
          if (r_byte == PRE_BYTE) begin
            state_next   = S_PREAMBLE;
            pre_cnt_next = 4'd1;
          end else begin
            state_next   = S_DROP;
            pre_err_next = 1'b1;
          end
        end
      end

      S_PREAMBLE: begin
        if (!r_dv) begin
          state_next   = S_IDLE;
          pre_err_next = 1'b1;
        end else if (r_byte == PRE_BYTE) begin
          pre_cnt_next = (pre_cnt_reg == PRE_CNT_MAX) ? pre_cnt_reg : pre_cnt_reg + 4'd1;
        end else if ((r_byte == SFD_BYTE) && pre_ok) begin
          state_next = S_PAYLOAD;
          crc_next   = CRC_INIT;
          len_next   = 16'd0;
          err_next   = 1'b0;
        end else begin
          state_next   = S_DROP;
          pre_err_next = 1'b1;
        end
      end

      S_PAYLOAD: begin
        if (r_dv) begin
          tdata_next  = r_byte;
          tvalid_next = 1'b1;
          crc_next    = crc_calc;
          len_next    = len_inc;
          err_next    = err_inc;
          // Raw dv at the pins is one byte ahead of r_dv, so it tells us this byte is the last.
          if (!rxctl_q1) begin
            tlast_next = 1'b1;
            tuser_next = frame_bad;
            bad_next   = frame_bad;
            ok_next    = ~frame_bad;
            state_next = S_IDLE;
          end
        end else begin
          // SFD immediately followed by carrier loss: nothing was emitted, so nothing to close.
          state_next = S_IDLE;
        end
      end

      S_DROP: begin
        // The input register reads 0 right after reset; ignore that one cycle so a frame
        // still streaming through reset is not mistaken for an idle gap.
        if (!r_dv && !rst_hold_reg) begin
          state_next = S_IDLE;
        end
      end

      default: state_next = S_DROP;
    endcase
  end

  assign m_axis_tdata   = tdata_reg;
  assign m_axis_tvalid  = tvalid_reg;
  assign m_axis_tlast   = tlast_reg;
  assign m_axis_tuser   = tuser_reg;
  assign stat_frame_ok  = ok_reg;
  assign stat_frame_bad = bad_reg;
  assign stat_pre_err   = pre_err_reg;

endmodule

// File: tb/tb_phy_rx_frame.sv
// Directed + randomized bench for phy_rx_frame: a per-cycle input stream is built, a
// segment-level reference model predicts every output cycle, and both DUT instances are compared.
module tb_phy_rx_frame;

  localparam int MIN_A = 1;
  localparam int MIN_B = 3;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       u;
    logic       o;
    logic       b;
    logic       p;
  } ob_t;

  logic       phy_clk = 1'b0;
  logic       phy_rst;
  logic [3:0] rxd_q1, rxd_q2;
  logic       rxctl_q1, rxctl_q2;

  logic [7:0] a_tdata, b_tdata;
  logic       a_tvalid, a_tlast, a_tuser, a_ok, a_bad, a_pre;
  logic       b_tvalid, b_tlast, b_tuser, b_ok, b_bad, b_pre;

  int checks   = 0;
  int failures = 0;

  byte unsigned s_byte[$];
  bit           s_dv[$];
  bit           s_er[$];
  bit           s_rst[$];
  byte unsigned f[$];
  byte unsigned g[$];

  always #5 phy_clk = ~phy_clk;

  phy_rx_frame #(.MIN_PREAMBLE(MIN_A), .MAX_LEN(1518)) dut_a (
    .phy_clk(phy_clk), .phy_rst(phy_rst),
    .rxd_q1(rxd_q1), .rxd_q2(rxd_q2), .rxctl_q1(rxctl_q1), .rxctl_q2(rxctl_q2),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast),
    .m_axis_tuser(a_tuser), .stat_frame_ok(a_ok), .stat_frame_bad(a_bad),
    .stat_pre_err(a_pre)
  );

  phy_rx_frame #(.MIN_PREAMBLE(MIN_B), .MAX_LEN(1518)) dut_b (
    .phy_clk(phy_clk), .phy_rst(phy_rst),
    .rxd_q1(rxd_q1), .rxd_q2(rxd_q2), .rxctl_q1(rxctl_q1), .rxctl_q2(rxctl_q2),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast),
    .m_axis_tuser(b_tuser), .stat_frame_ok(b_ok), .stat_frame_bad(b_bad),
    .stat_pre_err(b_pre)
  );

  // Standard Ethernet CRC-32 of the first n bytes (the value transmitted as FCS).
  function automatic logic [31:0] crc32(input byte unsigned d[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int len, output byte unsigned q[$]);
    logic [31:0] c;
    q = {};
    for (int i = 0; i < len - 4; i++) q.push_back(8'($urandom_range(0, 255)));
    c = crc32(q, len - 4);
    for (int b = 0; b < 4; b++) q.push_back(c[8*b +: 8]);
  endtask

  task automatic push(input byte unsigned b, input bit dv, input bit er, input bit rst);
    s_byte.push_back(b);
    s_dv.push_back(dv);
    s_er.push_back(er);
    s_rst.push_back(rst);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_frame(input byte unsigned q[$], input int npre, input int er_idx,
                            input int flip_idx);
    for (int i = 0; i < npre; i++) push(8'h55, 1'b1, 1'b0, 1'b0);
    push(8'hD5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < q.size(); i++)
      push(q[i] ^ ((i == flip_idx) ? 8'h04 : 8'h00), 1'b1, (i == er_idx), 1'b0);
  endtask

  // Reference model: every dv-high run is one burst seen from IDLE; a burst following
  // reset is discarded, a burst cut by reset never closes, reset zeroes the next output cycle.
  task automatic model(input int min_pre, output ob_t e[]);
    int n, k, st, en, np, i, len;
    bit after_rst, intr, err, fcs_ok, bad;
    byte unsigned pl[$];
    n = s_byte.size();
    e = new[n + 3];
    foreach (e[j]) e[j] = '0;
    k = 0;
    while (k < n) begin
      if (s_rst[k] || !s_dv[k]) begin
        k++;
        continue;
      end
      st = k;
      en = k;
      while (en + 1 < n && s_dv[en+1] && !s_rst[en+1]) en++;
      after_rst = (st > 0) && s_rst[st-1];
      intr      = (en + 1 < n) && s_rst[en+1];
      k = en + 1;
      if (after_rst) continue;
      np = 0;
      while (st + np <= en && s_byte[st+np] == 8'h55) np++;
      i = st + np;
      if (np == 0) begin
        e[st+2].p = 1'b1;
      end else if (i > en) begin
        if (!intr) e[en+3].p = 1'b1;
      end else if (s_byte[i] == 8'hD5 && ((np > 15) ? 15 : np) >= min_pre) begin
        pl = {};
        err = 1'b0;
        for (int j = i + 1; j <= en; j++) begin
          e[j+2].v = 1'b1;
          e[j+2].d = s_byte[j];
          pl.push_back(s_byte[j]);
          err |= s_er[j];
        end
        len = pl.size();
        if (!intr && len > 0) begin
          fcs_ok = (len >= 4) &&
                   ({pl[len-1], pl[len-2], pl[len-3], pl[len-4]} == crc32(pl, len - 4));
          bad = err || !fcs_ok || len < 64 || len > 1518;
          e[en+2].l = 1'b1;
          e[en+2].u = bad;
          e[en+2].o = !bad;
          e[en+2].b = bad;
        end
      end else begin
        e[i+2].p = 1'b1;
      end
    end
    for (int j = 0; j < n; j++) if (s_rst[j]) e[j+1] = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cmp(input string tag, input string nm, input int k, input ob_t o, input ob_t x);
    string t;
    t = $sformatf("%s.%s@%0d", tag, nm, k);
    chk({t, " tvalid"}, 32'(o.v), 32'(x.v));
    if (x.v) chk({t, " tdata"}, 32'(o.d), 32'(x.d));
    chk({t, " tlast"}, 32'(o.l), 32'(x.l));
    if (x.l) chk({t, " tuser"}, 32'(o.u), 32'(x.u));
    chk({t, " frame_ok"}, 32'(o.o), 32'(x.o));
    chk({t, " frame_bad"}, 32'(o.b), 32'(x.b));
    chk({t, " pre_err"}, 32'(o.p), 32'(x.p));
  endtask

  task automatic run(input string tag);
    ob_t ea[], eb[];
    ob_t oa, ob;
    int n, fe;
    n = s_byte.size();
    fe = failures;
    model(MIN_A, ea);
    model(MIN_B, eb);
    for (int k = 0; k < n + 3; k++) begin
      @(posedge phy_clk);
      #1;
      oa = '{v:a_tvalid, d:a_tdata, l:a_tlast, u:a_tuser, o:a_ok, b:a_bad, p:a_pre};
      ob = '{v:b_tvalid, d:b_tdata, l:b_tlast, u:b_tuser, o:b_ok, b:b_bad, p:b_pre};
      cmp(tag, "A", k, oa, ea[k]);
      cmp(tag, "B", k, ob, eb[k]);
      if (k < n) begin
        {rxd_q2, rxd_q1} = s_byte[k];
        rxctl_q1 = s_dv[k];
        rxctl_q2 = s_dv[k] ^ s_er[k];
        phy_rst  = s_rst[k];
      end else begin
        {rxd_q2, rxd_q1} = 8'h00;
        rxctl_q1 = 1'b0;
        rxctl_q2 = 1'b0;
        phy_rst  = 1'b0;
      end
    end
    $display("step %-10s cycles=%0d new_failures=%0d", tag, n, failures - fe);
    s_byte.delete();
    s_dv.delete();
    s_er.delete();
    s_rst.delete();
  endtask

  initial begin
    ob_t oa, ob;
    int len, npre, er_idx, flip_idx;

    phy_rst  = 1'b1;
    rxd_q1   = 4'h0;
    rxd_q2   = 4'h0;
    rxctl_q1 = 1'b0;
    rxctl_q2 = 1'b0;
    repeat (4) @(posedge phy_clk);
    #1;
    oa = '{v:a_tvalid, d:a_tdata, l:a_tlast, u:a_tuser, o:a_ok, b:a_bad, p:a_pre};
    ob = '{v:b_tvalid, d:b_tdata, l:b_tlast, u:b_tuser, o:b_ok, b:b_bad, p:b_pre};
    cmp("reset", "A", 0, oa, '0);
    cmp("reset", "B", 0, ob, '0);
    chk("reset.A tdata", 32'(a_tdata), 32'h0);
    phy_rst = 1'b0;

    // Good 64-byte frame, 7 preamble bytes
    push_idle(2); make_frame(64, f); push_frame(f, 7, -1, -1); push_idle(3);
    run("good64");

    // Same frame with one payload bit flipped
    push_idle(2); push_frame(f, 7, -1, 20); push_idle(3);
    run("flip");

    // RX_ER on payload byte 10, FCS still correct
    push_idle(2); push_frame(f, 7, 9, -1); push_idle(3);
    run("er10");

    // Length boundaries
    push_idle(2); make_frame(60, f); push_frame(f, 7, -1, -1); push_idle(3);
    run("runt60");
    push_idle(2); make_frame(1519, f); push_frame(f, 7, -1, -1); push_idle(3);
    run("giant1519");
    push_idle(2); make_frame(1518, f); push_frame(f, 7, -1, -1); push_idle(3);
    run("max1518");

    // Preamble errors, false carrier in the gaps
    push_idle(2);
    push(8'h55, 1, 0, 0); push(8'h55, 1, 0, 0); push(8'h57, 1, 0, 0);
    for (int i = 0; i < 10; i++) push(8'($urandom_range(0, 255)), 1, 0, 0);
    push(8'h0E, 0, 1, 0); push_idle(1);
    push(8'h55, 1, 0, 0); push(8'h55, 1, 0, 0); push(8'h55, 1, 0, 0);
    push_idle(1); push(8'h0E, 0, 1, 0);
    push(8'h12, 1, 0, 0); push(8'h55, 1, 0, 0); push_idle(3);
    run("pre_err");

    // Single 0x55 before SFD: accepted with MIN_PREAMBLE=1, rejected with 3
    push_idle(2); make_frame(64, f); push_frame(f, 1, -1, -1); push_idle(3);
    run("min_pre");

    // Back-to-back frames with one dv-low cycle between them
    push_idle(2); make_frame(64, f); make_frame(70, g);
    push_frame(f, 7, -1, -1); push_idle(1); push_frame(g, 7, -1, -1); push_idle(3);
    run("b2b");

    // Reset at payload byte 20 while dv stays high for 30 more bytes
    push_idle(2); make_frame(64, f); make_frame(64, g);
    for (int i = 0; i < 7; i++) push(8'h55, 1, 0, 0);
    push(8'hD5, 1, 0, 0);
    for (int i = 0; i < 19; i++) push(f[i], 1, 0, 0);
    push(f[19], 1, 0, 1); push(f[20], 1, 0, 1);
    for (int i = 0; i < 30; i++) push(8'($urandom_range(0, 255)), 1, 0, 0);
    push_idle(1); push_frame(g, 7, -1, -1); push_idle(3);
    run("reset_mid");

    // Randomized frames, preamble lengths, errors and gaps
    push_idle(2);
    for (int r = 0; r < 6; r++) begin
      len      = $urandom_range(58, 120);
      npre     = $urandom_range(1, 9);
      er_idx   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      flip_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      make_frame(len, f);
      push_frame(f, npre, er_idx, flip_idx);
      if ($urandom_range(0, 1) == 1) push(8'h0E, 0, 1, 0);
      push_idle($urandom_range(1, 3));
    end
    push_idle(3);
    run("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
